// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO block family.
//   - default data / error-index widths used by the FIFO, its ECC and the arbiter
//   - FIFO fill-status codes (0 empty, 1..4 quarter levels, 5 full)
//   - arbiter FSM state type
package fifo_pkg;

    localparam int FIFO_WIDTH   = 32;
    localparam int FIFO_ERRDATA = 6;
    localparam int FIFO_ERRPTR  = 4;

    localparam logic [2:0] FIFO_STATUS_EMPTY = 3'd0;
    localparam logic [2:0] FIFO_STATUS_FULL  = 3'd5;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req    : per-requester request vector
//   start  : index where the search begins (highest priority this round)
//   winner : one-hot grant, 0 when no request is pending
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   start,
    output logic [NREQ-1:0] winner
);

    logic [PW-1:0] idx;

    // Walk from the farthest position back toward start; the last hit written
    // is the one closest to start, which is the round-robin winner.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(start) + i) % NREQ);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin read arbiter in front of an ECC-protected FIFO.
// Grants one requester at a time, issues a single read (pop or peek) strobe,
// waits for the FIFO register file to capture, then returns the corrected
// data together with an error flag. An empty FIFO is answered directly.
//   clk, rst            : clock, synchronous active-high reset
//   req, req_peek       : per-requester request / peek qualifier
//   fifo_status         : FIFO fill code, sampled only when idle
//   fifo_out_reg        : registered corrected FIFO data
//   *_err_idx_reg       : registered error indices, 0 = clean
//   arbiter_rd_en/only  : read strobe and peek qualifier to the FIFO
//   gnt                 : one-hot owner of the current transaction
//   rsp_*               : response strobe, data, empty and corrected flags
//   err_cnt             : saturating count of corrected responses
//
// state | meaning
// IDLE  | no transaction; grant round-robin winner when any req is set
// ISSUE | one-cycle FIFO read strobe (pop or peek)
// WAIT  | FIFO register file captures the read data
// RESP  | response presented for one cycle
module fifo_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = FIFO_WIDTH,
    parameter int ERRDATA = FIFO_ERRDATA,
    parameter int ERRPTR  = FIFO_ERRPTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_peek,
    input  logic [2:0]         fifo_status,
    input  logic [WIDTH-1:0]   fifo_out_reg,
    input  logic [ERRDATA-1:0] data_err_idx_reg,
    input  logic [ERRPTR-1:0]  wr_ptr_err_idx_reg,
    input  logic [ERRPTR-1:0]  rd_ptr_err_idx_reg,
    output logic               arbiter_rd_en,
    output logic               arbiter_rd_only,
    output logic [NREQ-1:0]    gnt,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_empty,
    output logic               rsp_corr,
    output logic [7:0]         err_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   start_q, start_d, next_start;
    logic            peek_q, peek_d;
    logic            empty_q, empty_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [NREQ-1:0] winner;
    logic            any_err;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req    (req),
        .start  (start_q),
        .winner (winner)
    );

    assign any_err = (|data_err_idx_reg) | (|wr_ptr_err_idx_reg) | (|rd_ptr_err_idx_reg);

    // Search for the next round begins just past the index granted now.
    always_comb begin
        next_start = start_q;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) next_start = PW'((i + 1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            start_q   <= '0;
            peek_q    <= 1'b0;
            empty_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            start_q   <= start_d;
            peek_q    <= peek_d;
            empty_q   <= empty_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        start_d         = start_q;
        peek_d          = peek_q;
        empty_d         = empty_q;
        err_cnt_d       = err_cnt_q;
        arbiter_rd_en   = 1'b0;
        arbiter_rd_only = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        rsp_empty       = 1'b0;
        rsp_corr        = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    gnt_d   = winner;
                    start_d = next_start;
                    peek_d  = |(winner & req_peek);
                    if (fifo_status != FIFO_STATUS_EMPTY) begin
                        empty_d = 1'b0;
                        state_d = ARB_ISSUE;
                    end else begin
                        empty_d = 1'b1;
                        state_d = ARB_RESP;
                    end
                end
            end
            ARB_ISSUE: begin
                arbiter_rd_en   = 1'b1;
                arbiter_rd_only = peek_q;
                state_d         = ARB_WAIT;
            end
            ARB_WAIT: begin
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid = 1'b1;
                rsp_empty = empty_q;
                if (!empty_q) begin
                    rsp_data = fifo_out_reg;
                    rsp_corr = any_err;
                    if (any_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
module tb_fifo_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int ERRDATA = 6;
    localparam int ERRPTR  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_peek;
    logic [2:0]         fifo_status;
    logic [WIDTH-1:0]   fifo_out_reg;
    logic [ERRDATA-1:0] data_err_idx_reg;
    logic [ERRPTR-1:0]  wr_ptr_err_idx_reg;
    logic [ERRPTR-1:0]  rd_ptr_err_idx_reg;
    logic               arbiter_rd_en;
    logic               arbiter_rd_only;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_empty;
    logic               rsp_corr;
    logic [7:0]         err_cnt;

    fifo_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ERRDATA(ERRDATA), .ERRPTR(ERRPTR)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_peek           (req_peek),
        .fifo_status        (fifo_status),
        .fifo_out_reg       (fifo_out_reg),
        .data_err_idx_reg   (data_err_idx_reg),
        .wr_ptr_err_idx_reg (wr_ptr_err_idx_reg),
        .rd_ptr_err_idx_reg (rd_ptr_err_idx_reg),
        .arbiter_rd_en      (arbiter_rd_en),
        .arbiter_rd_only    (arbiter_rd_only),
        .gnt                (gnt),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_empty          (rsp_empty),
        .rsp_corr           (rsp_corr),
        .err_cnt            (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: a transaction is either idle (age 0) or
    // 'age' cycles old counted from the grant. A non-empty read strobes in its
    // first cycle and answers in its third; an empty one answers in its first.
    int m_age;
    int m_owner;
    int m_start;
    int m_errcnt;
    bit m_empty;
    bit m_peek;

    task automatic model_reset();
        m_age    = 0;
        m_owner  = 0;
        m_start  = 0;
        m_errcnt = 0;
        m_empty  = 1'b0;
        m_peek   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] e_gnt;
        logic            e_rd, e_only, e_valid, e_empty, e_corr;
        logic [WIDTH-1:0] e_data;
        int              resp_age;
        int              idx;
        bit              errs;
        @(negedge clk);
        errs     = (data_err_idx_reg != 0) || (wr_ptr_err_idx_reg != 0) || (rd_ptr_err_idx_reg != 0);
        e_gnt    = '0;
        e_rd     = 1'b0;
        e_only   = 1'b0;
        e_valid  = 1'b0;
        e_empty  = 1'b0;
        e_corr   = 1'b0;
        e_data   = '0;
        resp_age = m_empty ? 1 : 3;
        if (m_age > 0) begin
            e_gnt = NREQ'(1) << m_owner;
            if (!m_empty && m_age == 1) begin
                e_rd   = 1'b1;
                e_only = m_peek;
            end
            if (m_age == resp_age) begin
                e_valid = 1'b1;
                e_empty = m_empty;
                if (!m_empty) begin
                    e_data = fifo_out_reg;
                    e_corr = errs;
                end
            end
        end
        check("gnt",       32'(gnt),             32'(e_gnt));
        check("rd_en",     32'(arbiter_rd_en),   32'(e_rd));
        check("rd_only",   32'(arbiter_rd_only), 32'(e_only));
        check("rsp_valid", 32'(rsp_valid),       32'(e_valid));
        check("rsp_data",  32'(rsp_data),        32'(e_data));
        check("rsp_empty", 32'(rsp_empty),       32'(e_empty));
        check("rsp_corr",  32'(rsp_corr),        32'(e_corr));
        check("err_cnt",   32'(err_cnt),         32'(m_errcnt));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_age == 0) begin
            if (req != 0) begin
                idx = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (idx < 0 && req[(m_start + k) % NREQ]) idx = (m_start + k) % NREQ;
                end
                m_owner = idx;
                m_start = (idx + 1) % NREQ;
                m_peek  = req_peek[idx];
                m_empty = (fifo_status == 3'd0);
                m_age   = 1;
            end
        end else if (m_age == resp_age) begin
            if (e_corr && m_errcnt < 255) m_errcnt++;
            m_age = 0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst                = 1'b1;
        req                = '0;
        req_peek           = '0;
        fifo_status        = 3'd0;
        fifo_out_reg       = '0;
        data_err_idx_reg   = '0;
        wr_ptr_err_idx_reg = '0;
        rd_ptr_err_idx_reg = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // single pop
        req          = 4'b0001;
        fifo_status  = 3'd2;
        fifo_out_reg = 32'hDEADBEEF;
        repeat (4) cycle();
        req = '0;
        cycle();

        // all requesters held: rotating grants
        req         = 4'b1111;
        fifo_status = 3'd3;
        repeat (20) cycle();
        req = '0;
        repeat (2) cycle();

        // peek
        req          = 4'b0010;
        req_peek     = 4'b0010;
        fifo_status  = 3'd1;
        fifo_out_reg = 32'h1234_5678;
        repeat (4) cycle();
        req      = '0;
        req_peek = '0;
        cycle();

        // empty FIFO answered directly
        req         = 4'b0100;
        fifo_status = 3'd0;
        repeat (2) cycle();
        req = '0;
        cycle();

        // req dropped right after grant, status changes mid-transaction
        req         = 4'b1000;
        fifo_status = 3'd5;
        cycle();
        req         = '0;
        fifo_status = 3'd0;
        repeat (4) cycle();

        // error counter saturation over 300 corrected responses
        req              = 4'b0001;
        fifo_status      = 3'd2;
        data_err_idx_reg = 6'd5;
        repeat (300 * 4) cycle();
        req = '0;
        cycle();
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        data_err_idx_reg = '0;

        // reset while in WAIT aborts the read
        req         = 4'b0010;
        fifo_status = 3'd4;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b1111;
        repeat (6) cycle();
        req = '0;
        repeat (2) cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst                = ($urandom_range(0, 63) == 0);
            req                = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            req_peek           = NREQ'($urandom);
            fifo_status        = 3'($urandom_range(0, 5));
            fifo_out_reg       = $urandom;
            data_err_idx_reg   = ($urandom_range(0, 3) == 0) ? ERRDATA'($urandom) : '0;
            wr_ptr_err_idx_reg = ($urandom_range(0, 7) == 0) ? ERRPTR'($urandom) : '0;
            rd_ptr_err_idx_reg = ($urandom_range(0, 7) == 0) ? ERRPTR'($urandom) : '0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters; WIDTH, 32, data width; ERRDATA, 6, data error index width; ERRPTR, 4, pointer error index width.
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  NREQ  per-requester read request, level, held until own rsp_valid.
REQ-006 req_peek  in  NREQ  per-requester peek qualifier: 1 = read without pop.
REQ-007 fifo_status  in  3  FIFO fill code: 0 empty, 1-4 quarter levels, 5 full.
REQ-008 fifo_out_reg  in  WIDTH  registered corrected FIFO data.
REQ-009 data_err_idx_reg, wr_ptr_err_idx_reg, rd_ptr_err_idx_reg  in  ERRDATA/ERRPTR/ERRPTR  registered error indices, 0 = clean.
REQ-010 arbiter_rd_en  out  1  FIFO read strobe; arbiter_rd_only  out  1  peek qualifier to FIFO.
REQ-011 gnt  out  NREQ  one-hot owner of current transaction, 0 when idle.
REQ-012 rsp_valid  out  1; rsp_data  out  WIDTH; rsp_empty  out  1; rsp_corr  out  1 (any error index nonzero).
REQ-013 err_cnt  out  8  saturating count of responses with rsp_corr=1.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding is internal.
REQ-015 IDLE: when any req bit is 1, the round-robin winner SHALL be latched into gnt; with fifo_status!=0 go to ISSUE, otherwise go to RESP with rsp_empty=1.
REQ-016 ISSUE (exactly 1 cycle): arbiter_rd_en=1, arbiter_rd_only=req_peek[winner] latched at grant; next WAIT.
REQ-017 WAIT (1 cycle): no strobes; accounts for FIFO register-file capture; next RESP.
REQ-018 RESP (1 cycle): rsp_valid=1, rsp_data=fifo_out_reg (0 when rsp_empty), rsp_corr=OR-reduce of the three error indices (0 when rsp_empty); next IDLE.
REQ-019 Latency: non-empty grant at cycle t (IDLE->ISSUE edge) SHALL give rsp_valid at ISSUE+2; empty grant SHALL give rsp_valid in the cycle after grant.
REQ-020 gnt SHALL stay constant from grant through RESP and drop to 0 in IDLE.
REQ-021 Round robin: search starts at last-granted index+1 modulo NREQ; the pointer SHALL update only on grant; after reset the search starts at index 0.
REQ-022 Deasserting req after grant SHALL NOT abort the transaction; the response is still produced.
REQ-023 Minimum spacing between consecutive arbiter_rd_en pulses SHALL be 4 cycles; back-to-back grants are allowed from IDLE after RESP.
REQ-024 fifo_status sampled only in IDLE; changes during ISSUE/WAIT/RESP SHALL be ignored.
REQ-025 err_cnt SHALL increment by 1 in RESP when rsp_corr=1 and saturate at 255.
REQ-026 Peek and pop SHALL follow identical timing; only arbiter_rd_only differs.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, gnt=0, arbiter_rd_en=0, arbiter_rd_only=0, rsp_valid=0, rsp_data=0, rsp_empty=0, rsp_corr=0, err_cnt=0, RR pointer=0, aborting any transaction without a response.
REQ-028 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the FIFO status codes (EMPTY=0, FULL=5) and the default WIDTH/ERRDATA/ERRPTR constants used across the FIFO blocks.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer -> one-hot winner, combinational); the FSM, latching and counter remain in fifo_arbiter.

Verification
REQ-031 Reset, then req=0001, status=2, fifo_out_reg=0xDEADBEEF, errors 0 -> rd_en 1 cycle, rd_only=0, rsp_valid 2 cycles later, rsp_data=0xDEADBEEF, gnt=0001.
REQ-032 req=1111 held continuously, status=3 -> grants in order 0001,0010,0100,1000,0001, rd_en every 4 cycles.
REQ-033 req=0010, req_peek=0010, status=1 -> rd_en with rd_only=1; response timing matches pop.
REQ-034 status=0, req=0100 -> no rd_en, rsp_valid next cycle, rsp_empty=1, rsp_data=0.
REQ-035 data_err_idx_reg=5 for 300 responses -> rsp_corr=1 each, err_cnt stops at 255.
REQ-036 rst=1 in WAIT -> next cycle IDLE, no rsp_valid, all outputs 0, next grant to index 0.
